sw_array_controller: RTL and testbench
======================================

Name: sw_array_controller

Overview:
- Sequences one job on the Smith-Waterman systolic array of LENGTH processing elements.
- Per job: loads the query bases into the per-PE query lanes, holds the array in reset during load, then streams the target bases into PE0 as one contiguous enable burst.
- After the burst, waits for the last PE's valid flag, captures its high score, unbiases it and returns it through a valid/ready result port.
- Sits between the host/DMA stream interfaces and the PE chain.

Parameters:
SCORE_WIDTH, 12, score width of PE buses
LENGTH, 16, number of PEs (query length per job)
LOG2LENGTH, 4, width of query index counter
TLEN_W, 12, width of target length counter; max target = 2**TLEN_W-1 bases
DRAIN_MAX, 2*LENGTH+4, cycles allowed from burst end to last-PE valid

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  job start pulse, honoured only in IDLE
q_valid  in  1  query base valid
q_base  in  2  query base (A=00,G=01,T=10,C=11)
q_ready  out  1  query base accepted when q_valid&q_ready
t_valid  in  1  target base valid
t_base  in  2  target base
t_last  in  1  marks final target base
t_ready  out  1  target base accepted when t_valid&t_ready
arr_rst_n  out  1  active-low reset to all PEs
arr_query  out  2*LENGTH  query lanes; bits [2i+1:2i] drive PE i
arr_data  out  2  data_in of PE0
arr_en  out  1  en_in of PE0
arr_vld_last  in  1  vld of PE LENGTH-1
arr_high_last  in  SCORE_WIDTH  High_out of PE LENGTH-1
res_valid  out  1  result available
res_ready  in  1  result consumed when res_valid&res_ready
res_score  out  SCORE_WIDTH  unbiased best local score
res_err  out  3  {len_overflow, drain_timeout, underflow}
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (async, active-high): state=IDLE. Outputs: arr_rst_n=0, arr_query=0, arr_data=0, arr_en=0, q_ready=0, t_ready=0, res_valid=0, res_score=0, res_err=0, busy=0. All counters are cleared.
- All outputs are registered.
- arr_rst_n=0 in IDLE and LOAD_Q; arr_rst_n=1 in STREAM, DRAIN and RESULT.
- IDLE:
  - start=1 -> LOAD_Q; qidx=0; res_err cleared.
  - Query/target traffic is not accepted (q_ready=t_ready=0).
- LOAD_Q:
  - q_ready=1. Each accepted base is written to lane qidx, then qidx increments.
  - The accept of lane LENGTH-1 -> STREAM.
  - A t_last arriving here is ignored (t_ready=0).
- STREAM:
  - t_ready=1. Each accepted base gives arr_data<=t_base and arr_en<=1 on the next cycle (latency 1). tcnt increments per accepted base.
  - Before the first accept, arr_en=0; waiting is unlimited.
  - After the first accept, t_valid=0 on any cycle before t_last is underflow, because a gap would end the PE computation early. Response: res_err[0]=1, arr_en<=0, go to DRAIN.
  - Accepted base with t_last=1: the next cycle arr_en<=0, t_ready<=0, go to DRAIN, dcnt=0.
  - tcnt reaching 2**TLEN_W-1 without t_last: that base is treated as last and res_err[2]=1.
- DRAIN:
  - arr_en=0, t_ready=0, and dcnt increments each cycle.
  - arr_vld_last=1: capture res_score = arr_high_last - 2**(SCORE_WIDTH-1), saturated to 0 when arr_high_last < 2**(SCORE_WIDTH-1). Set res_valid=1 and go to RESULT.
  - dcnt == DRAIN_MAX without vld: res_err[1]=1, res_score=0, res_valid=1, go to RESULT.
  - If vld and timeout occur in the same cycle, vld wins.
- RESULT:
  - res_valid and res_score are held stable until res_ready=1.
  - On the handshake: res_valid<=0, go to IDLE. Entering IDLE drops arr_rst_n, which clears the PEs.
  - res_ready may already be high on entry; the handshake then completes in that cycle.
- start outside IDLE is ignored.
- rst asserted mid-job: immediate return to IDLE. The array is held in reset, the partial query is discarded and no result is produced.
- arr_query persists until overwritten by the next LOAD_Q.

Decomposition:
- Shared package sw_pkg holds:
  - base encoding constants _A/_G/_T/_C
  - state localparams IDLE/LOAD_Q/STREAM/DRAIN/RESULT (one-hot, 5 bits)
  - error bit indices
  - bias constant 2**(SCORE_WIDTH-1)
- One sub-module sw_query_lanes: a LENGTH x 2-bit register file with write enable and index, whose outputs are flattened to arr_query.
- The FSM and counters stay in the top-level module.

Test Plan (LENGTH=4, SCORE_WIDTH=12):
1. Nominal job:
   - Stimulus: start; load query A,G,T,C; stream 6 target bases with t_last on the 6th; model returns vld with high=0x805.
   - Required: arr_query=0xE4; arr_en high exactly 6 cycles, 1 cycle after each accept; res_score=5, res_err=0.
2. Underflow:
   - Stimulus: t_valid drops for 1 cycle after 3 bases.
   - Required: res_err=3'b001; arr_en low the cycle after the gap; result still delivered.
3. Drain timeout:
   - Stimulus: vld is never asserted.
   - Required: res_valid exactly DRAIN_MAX=12 cycles after DRAIN entry; res_err=3'b010; res_score=0.
4. Backpressure:
   - Stimulus: res_ready held low 10 cycles.
   - Required: res_valid/res_score stable; busy=1; a start pulse during the hold is ignored; IDLE is reached one cycle after res_ready.
5. Saturation:
   - Stimulus: arr_high_last=0x7F0 (below bias).
   - Required: res_score=0.
6. Mid-job reset:
   - Stimulus: rst asserted during STREAM after 2 bases.
   - Required: asynchronously arr_rst_n=0, arr_en=0, busy=0, t_ready=0; a following job with a new query runs clean and matches scenario 1.

Source files
------------

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array controller: base encoding,
// controller state codes, error flag positions and the score bias helper.
package sw_pkg;

    // Nucleotide encoding on the 2-bit base buses
    localparam logic [1:0] _A = 2'b00;
    localparam logic [1:0] _G = 2'b01;
    localparam logic [1:0] _T = 2'b10;
    localparam logic [1:0] _C = 2'b11;

    // Controller states, one-hot
    localparam logic [4:0] IDLE   = 5'b00001;
    localparam logic [4:0] LOAD_Q = 5'b00010;
    localparam logic [4:0] STREAM = 5'b00100;
    localparam logic [4:0] DRAIN  = 5'b01000;
    localparam logic [4:0] RESULT = 5'b10000;

    // Bit positions inside res_err
    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_TIMEOUT   = 1;
    localparam int ERR_LEN_OVF   = 2;

    // PE scores are offset by half the score range so they never go negative
    localparam int DEFAULT_SCORE_WIDTH = 12;

    function automatic int sw_bias(input int score_width);
        return 1 << (score_width - 1);
    endfunction

    localparam int SCORE_BIAS = sw_bias(DEFAULT_SCORE_WIDTH);

endpackage

// File: rtl/sw_query_lanes.sv
// Query register file: one 2-bit base per PE, written one lane at a time,
// presented as a flat bus so lane i drives bits [2i+1:2i].
import sw_pkg::*;

module sw_query_lanes #(
    parameter int LENGTH     = 16,
    parameter int LOG2LENGTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [LOG2LENGTH-1:0]   widx,
    input  logic [1:0]              wdata,
    output logic [2*LENGTH-1:0]     lanes
);

    genvar gi;
    generate
        for (gi = 0; gi < LENGTH; gi++) begin : g_lane
            logic [1:0] lane_reg;

            // Capture the base addressed to this lane; value persists between jobs
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg <= _A;
                end else if (we && (widx == LOG2LENGTH'(gi))) begin
                    lane_reg <= wdata;
                end
            end

            assign lanes[2*gi +: 2] = lane_reg;
        end
    endgenerate

endmodule

// File: rtl/sw_array_controller.sv
// Job sequencer for the Smith-Waterman systolic array: loads the query lanes
// with the array held in reset, streams the target into PE0 as one unbroken
// enable burst, then waits for the last PE and returns its unbiased score.
import sw_pkg::*;

module sw_array_controller #(
    parameter int SCORE_WIDTH = 12,
    parameter int LENGTH      = 16,
    parameter int LOG2LENGTH  = 4,
    parameter int TLEN_W      = 12,
    parameter int DRAIN_MAX   = 2*LENGTH + 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    q_valid,
    input  logic [1:0]              q_base,
    output logic                    q_ready,
    input  logic                    t_valid,
    input  logic [1:0]              t_base,
    input  logic                    t_last,
    output logic                    t_ready,
    output logic                    arr_rst_n,
    output logic [2*LENGTH-1:0]     arr_query,
    output logic [1:0]              arr_data,
    output logic                    arr_en,
    input  logic                    arr_vld_last,
    input  logic [SCORE_WIDTH-1:0]  arr_high_last,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [SCORE_WIDTH-1:0]  res_score,
    output logic [2:0]              res_err,
    output logic                    busy
);

    localparam int DCNT_W = $clog2(DRAIN_MAX + 1);
    localparam logic [SCORE_WIDTH-1:0] BIAS       = SCORE_WIDTH'(sw_bias(SCORE_WIDTH));
    localparam logic [LOG2LENGTH-1:0]  QIDX_LAST  = LOG2LENGTH'(LENGTH - 1);
    // Value of tcnt just before the accept that would reach the length limit
    localparam logic [TLEN_W-1:0]      TCNT_LAST  = TLEN_W'((2**TLEN_W) - 2);
    // dcnt value on the DRAIN_MAX-th cycle spent in DRAIN
    localparam logic [DCNT_W-1:0]      DRAIN_LAST = DCNT_W'(DRAIN_MAX - 1);

    logic [4:0]             state_reg, state_next;
    logic [LOG2LENGTH-1:0]  qidx_reg;
    logic [TLEN_W-1:0]      tcnt_reg;
    logic [DCNT_W-1:0]      dcnt_reg;
    logic                   started_reg;
    logic                   q_ready_reg, t_ready_reg, busy_reg, arr_rst_n_reg;
    logic [1:0]             arr_data_reg;
    logic                   arr_en_reg;
    logic                   res_valid_reg;
    logic [SCORE_WIDTH-1:0] res_score_reg;
    logic [2:0]             res_err_reg;

    logic                   q_accept, t_accept, t_final, underflow;
    logic [SCORE_WIDTH-1:0] unbiased;

    assign q_accept  = q_valid & q_ready_reg;
    assign t_accept  = t_valid & t_ready_reg;
    // A base that hits the length limit closes the burst just like t_last
    assign t_final   = t_last | (tcnt_reg == TCNT_LAST);
    // Once the burst has started, any bubble would stall the PE wavefront
    assign underflow = started_reg & ~t_valid;
    assign unbiased  = (arr_high_last >= BIAS) ? (arr_high_last - BIAS) : '0;

    sw_query_lanes #(
        .LENGTH     (LENGTH),
        .LOG2LENGTH (LOG2LENGTH)
    ) u_lanes (
        .clk   (clk),
        .rst   (rst),
        .we    (q_accept),
        .widx  (qidx_reg),
        .wdata (q_base),
        .lanes (arr_query)
    );

    // Next-state selection for the job sequence
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (start) state_next = LOAD_Q;
            LOAD_Q: if (q_accept && (qidx_reg == QIDX_LAST)) state_next = STREAM;
            STREAM: begin
                if (t_accept && t_final)  state_next = DRAIN;
                else if (underflow)       state_next = DRAIN;
            end
            DRAIN:  if (arr_vld_last || (dcnt_reg == DRAIN_LAST)) state_next = RESULT;
            RESULT: if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, counters and all registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            qidx_reg      <= '0;
            tcnt_reg      <= '0;
            dcnt_reg      <= '0;
            started_reg   <= 1'b0;
            q_ready_reg   <= 1'b0;
            t_ready_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            arr_rst_n_reg <= 1'b0;
            arr_data_reg  <= '0;
            arr_en_reg    <= 1'b0;
            res_valid_reg <= 1'b0;
            res_score_reg <= '0;
            res_err_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            q_ready_reg   <= (state_next == LOAD_Q);
            t_ready_reg   <= (state_next == STREAM);
            busy_reg      <= (state_next != IDLE);
            arr_rst_n_reg <= (state_next inside {STREAM, DRAIN, RESULT});

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        qidx_reg    <= '0;
                        tcnt_reg    <= '0;
                        dcnt_reg    <= '0;
                        started_reg <= 1'b0;
                        res_err_reg <= '0;
                    end
                end
                LOAD_Q: begin
                    if (q_accept) qidx_reg <= qidx_reg + LOG2LENGTH'(1);
                end
                STREAM: begin
                    arr_en_reg <= t_accept;
                    dcnt_reg   <= '0;
                    if (t_accept) begin
                        arr_data_reg <= t_base;
                        tcnt_reg     <= tcnt_reg + TLEN_W'(1);
                        started_reg  <= 1'b1;
                        if (!t_last && (tcnt_reg == TCNT_LAST))
                            res_err_reg[ERR_LEN_OVF] <= 1'b1;
                    end else if (underflow) begin
                        res_err_reg[ERR_UNDERFLOW] <= 1'b1;
                    end
                end
                DRAIN: begin
                    arr_en_reg <= 1'b0;
                    dcnt_reg   <= dcnt_reg + DCNT_W'(1);
                    // A valid arriving on the final drain cycle still wins
                    if (arr_vld_last) begin
                        res_score_reg <= unbiased;
                        res_valid_reg <= 1'b1;
                    end else if (dcnt_reg == DRAIN_LAST) begin
                        res_err_reg[ERR_TIMEOUT] <= 1'b1;
                        res_score_reg            <= '0;
                        res_valid_reg            <= 1'b1;
                    end
                end
                RESULT: begin
                    if (res_ready) res_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign q_ready   = q_ready_reg;
    assign t_ready   = t_ready_reg;
    assign busy      = busy_reg;
    assign arr_rst_n = arr_rst_n_reg;
    assign arr_data  = arr_data_reg;
    assign arr_en    = arr_en_reg;
    assign res_valid = res_valid_reg;
    assign res_score = res_score_reg;
    assign res_err   = res_err_reg;

endmodule

// File: tb/tb_sw_array_controller.sv
// Randomised scoreboard bench for sw_array_controller (LENGTH=4, SCORE_WIDTH=12).
import sw_pkg::*;

module tb_sw_array_controller;

    localparam int SW   = 12;
    localparam int LEN  = 4;
    localparam int L2   = 2;
    localparam int TW   = 12;
    localparam int DMAX = 2*LEN + 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            q_valid = 1'b0;
    logic [1:0]      q_base = '0;
    logic            q_ready;
    logic            t_valid = 1'b0;
    logic [1:0]      t_base = '0;
    logic            t_last = 1'b0;
    logic            t_ready;
    logic            arr_rst_n;
    logic [2*LEN-1:0] arr_query;
    logic [1:0]      arr_data;
    logic            arr_en;
    logic            arr_vld_last = 1'b0;
    logic [SW-1:0]   arr_high_last = '0;
    logic            res_valid;
    logic            res_ready = 1'b0;
    logic [SW-1:0]   res_score;
    logic [2:0]      res_err;
    logic            busy;

    sw_array_controller #(
        .SCORE_WIDTH (SW),
        .LENGTH      (LEN),
        .LOG2LENGTH  (L2),
        .TLEN_W      (TW),
        .DRAIN_MAX   (DMAX)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .q_valid       (q_valid),
        .q_base        (q_base),
        .q_ready       (q_ready),
        .t_valid       (t_valid),
        .t_base        (t_base),
        .t_last        (t_last),
        .t_ready       (t_ready),
        .arr_rst_n     (arr_rst_n),
        .arr_query     (arr_query),
        .arr_data      (arr_data),
        .arr_en        (arr_en),
        .arr_vld_last  (arr_vld_last),
        .arr_high_last (arr_high_last),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_score     (res_score),
        .res_err       (res_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct { logic [SW-1:0] score; logic [2:0] err; } res_t;
    typedef struct { logic [1:0] base; int stamp; } dat_t;

    res_t sb_q[$];
    dat_t dq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   en_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference rule: best local score is the PE high minus half range, floored at zero
    function automatic logic [SW-1:0] model_score(input int high);
        int s;
        s = high - (1 << (SW - 1));
        if (s < 0) s = 0;
        return SW'(s);
    endfunction

    // Monitor: checks the PE0 burst against accepted bases and results against the scoreboard
    initial begin
        bit            held;
        logic [SW-1:0] held_score;
        res_t          r;
        dat_t          d;
        held = 1'b0;
        held_score = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (arr_en) begin
                    en_count++;
                    if (dq.size() == 0) begin
                        fail("arr_en_unexpected", 32'(arr_en), 0);
                    end else begin
                        d = dq.pop_front();
                        chk("arr_en_latency", 32'(cyc - d.stamp), 1);
                        chk("arr_data", 32'(arr_data), 32'(d.base));
                    end
                end else if (dq.size() > 0 && dq[0].stamp < cyc) begin
                    fail("arr_en_missing", 32'(arr_en), 1);
                    void'(dq.pop_front());
                end
                if (res_valid) begin
                    if (held) chk("res_score_stable", 32'(res_score), 32'(held_score));
                    held = 1'b1;
                    held_score = res_score;
                    if (res_ready) begin
                        held = 1'b0;
                        if (sb_q.size() == 0) begin
                            fail("unexpected_result", 32'(res_score), 0);
                        end else begin
                            r = sb_q.pop_front();
                            $display("result: score=0x%0h err=%b (expected 0x%0h %b)", res_score, res_err, r.score, r.err);
                            chk("res_score", 32'(res_score), 32'(r.score));
                            chk("res_err", 32'(res_err), 32'(r.err));
                        end
                    end
                end else begin
                    held = 1'b0;
                end
            end
        end
    end

    task automatic start_and_load(input logic [2*LEN-1:0] query);
        int w;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_load", 32'(busy), 1);
        chk("arr_rst_n_load", 32'(arr_rst_n), 0);
        for (int i = 0; i < LEN; i++) begin
            q_valid = 1'b1;
            q_base  = query[2*i +: 2];
            w = 0;
            while (!q_ready && w < 50) begin
                @(negedge clk);
                w++;
            end
            if (w >= 50) fail("q_ready_wait", 32'(q_ready), 1);
            @(negedge clk);
        end
        q_valid = 1'b0;
        chk("arr_query", 32'(arr_query), 32'(query));
        chk("t_ready_stream", 32'(t_ready), 1);
        chk("arr_rst_n_stream", 32'(arr_rst_n), 1);
    endtask

    // One full job: vld_delay<0 means the last PE never reports; hold<0 raises res_ready before the result
    task automatic run_job(input logic [2*LEN-1:0] query, input int ntgt, input bit send_last,
                           input int gap_after, input int vld_delay, input logic [SW-1:0] high,
                           input int hold, input bit start_in_hold, input int pre_wait);
        res_t exp_r;
        int   nacc;
        int   w;
        exp_r.err = 3'b000;
        if (gap_after >= 0) exp_r.err[ERR_UNDERFLOW] = 1'b1;
        if (vld_delay < 0)  exp_r.err[ERR_TIMEOUT]   = 1'b1;
        if (!send_last)     exp_r.err[ERR_LEN_OVF]   = 1'b1;
        exp_r.score = (vld_delay < 0) ? '0 : model_score(int'(high));
        nacc = (gap_after >= 0) ? gap_after : ntgt;
        en_count = 0;
        sb_q.push_back(exp_r);

        start_and_load(query);
        repeat (pre_wait) @(negedge clk);
        for (int j = 0; j < nacc; j++) begin
            t_valid = 1'b1;
            t_base  = 2'($urandom);
            t_last  = send_last && (gap_after < 0) && (j == ntgt - 1);
            if (t_ready) dq.push_back('{base: t_base, stamp: cyc});
            else fail("t_ready_during_burst", 32'(t_ready), 1);
            @(negedge clk);
        end
        t_valid = 1'b0;
        t_last  = 1'b0;
        if (gap_after >= 0) @(negedge clk);
        chk("t_ready_drain", 32'(t_ready), 0);
        if (hold < 0) res_ready = 1'b1;

        if (vld_delay >= 0) begin
            repeat (vld_delay) @(negedge clk);
            chk("res_valid_before_vld", 32'(res_valid), 0);
            arr_vld_last  = 1'b1;
            arr_high_last = high;
            @(negedge clk);
            arr_vld_last  = 1'b0;
            arr_high_last = SW'($urandom);
        end else begin
            w = 0;
            while (!res_valid && w < 40) begin
                @(negedge clk);
                w++;
            end
            chk("drain_timeout_cycles", 32'(w), DMAX);
        end
        chk("res_valid_up", 32'(res_valid), 1);

        for (int h = 0; h < hold; h++) begin
            chk("busy_hold", 32'(busy), 1);
            start = start_in_hold && (h == 0);
            @(negedge clk);
            start = 1'b0;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("busy_idle", 32'(busy), 0);
        chk("res_valid_clear", 32'(res_valid), 0);
        chk("arr_rst_n_idle", 32'(arr_rst_n), 0);
        @(negedge clk);
        chk("q_ready_idle", 32'(q_ready), 0);
        chk("en_burst_len", 32'(en_count), 32'(nacc));
        $display("job: query=0x%0h tgt=%0d gap=%0d vld=%0d high=0x%0h hold=%0d", query, ntgt, gap_after, vld_delay, high, hold);
    endtask

    initial begin
        logic [2*LEN-1:0] q_nom;
        int g;
        int nt;
        q_nom = {_C, _T, _G, _A};

        #1;
        chk("rst_arr_rst_n", 32'(arr_rst_n), 0);
        chk("rst_arr_query", 32'(arr_query), 0);
        chk("rst_arr_en", 32'(arr_en), 0);
        chk("rst_q_ready", 32'(q_ready), 0);
        chk("rst_t_ready", 32'(t_ready), 0);
        chk("rst_res_valid", 32'(res_valid), 0);
        chk("rst_res_score", 32'(res_score), 0);
        chk("rst_res_err", 32'(res_err), 0);
        chk("rst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_job(q_nom, 6, 1'b1, -1, 2, 12'h805, 0, 1'b0, 0);          // nominal
        run_job(8'h1B, 6, 1'b1, 3, 1, 12'h810, 0, 1'b0, 1);           // underflow
        run_job(8'h39, 5, 1'b1, -1, -1, 12'h900, 0, 1'b0, 0);         // drain timeout
        run_job(8'hC6, 4, 1'b1, -1, 3, 12'h9AB, 10, 1'b1, 0);         // backpressure
        run_job(8'h72, 3, 1'b1, -1, 0, 12'h7F0, 0, 1'b0, 2);          // saturation
        run_job(8'h4D, 2, 1'b1, -1, DMAX - 1, 12'h8FF, 0, 1'b0, 0);   // vld on final drain cycle
        run_job(8'hA5, 7, 1'b1, -1, 4, 12'hFFF, -1, 1'b0, 0);         // res_ready high on entry

        // Mid-job reset during the burst
        sb_q.push_back('{score: '0, err: 3'b000});
        start_and_load(8'h5A);
        for (int j = 0; j < 2; j++) begin
            t_valid = 1'b1;
            t_base  = 2'($urandom);
            dq.push_back('{base: t_base, stamp: cyc});
            @(negedge clk);
        end
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_arr_rst_n", 32'(arr_rst_n), 0);
        chk("midrst_arr_en", 32'(arr_en), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_t_ready", 32'(t_ready), 0);
        chk("midrst_res_valid", 32'(res_valid), 0);
        t_valid = 1'b0;
        dq.delete();
        void'(sb_q.pop_back());
        $display("job: mid-stream reset applied");
        @(negedge clk);
        rst = 1'b0;
        run_job(q_nom, 6, 1'b1, -1, 2, 12'h805, 0, 1'b0, 0);

        run_job(8'hE1, (1 << TW) - 1, 1'b0, -1, 1, 12'h850, 0, 1'b0, 0); // length limit

        for (int k = 0; k < 10; k++) begin
            nt = $urandom_range(2, 10);
            g  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nt - 1) : -1;
            run_job(8'($urandom), nt, 1'b1, g,
                    ($urandom_range(0, 4) == 0) ? -1 : $urandom_range(0, DMAX - 1),
                    SW'($urandom), $urandom_range(0, 4) - 1, 1'($urandom), $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 0);
        chk("data_queue_drained", 32'(dq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
